// File: rtl/nw_pkg.sv
// Shared symbol codes, score constants, FSM encoding and per-state control decode
// for the NW alignment control path.
package nw_pkg;

  localparam logic [2:0] SYM_A = 3'b100;
  localparam logic [2:0] SYM_C = 3'b110;
  localparam logic [2:0] SYM_G = 3'b001;
  localparam logic [2:0] SYM_T = 3'b011;

  localparam int SCORE_GAP      = -2;
  localparam int SCORE_MATCH    = 1;
  localparam int SCORE_MISMATCH = -1;

  typedef enum logic [2:0] {IDLE, INIT, READ, INS, NEXT, TRACE, DONE, ERR} state_t;

  typedef struct packed {
    logic en_init;
    logic en_read;
    logic en_ins;
    logic we;
    logic change_index;
    logic en_traceB;
    logic busy;
    logic done;
    logic err;
  } ctl_t;

  // Moore decode; registered against the next state so outputs line up with it.
  function automatic ctl_t ctl_of(state_t s);
    ctl_t c;
    c              = '0;
    c.en_init      = (s == INIT);
    c.en_read      = (s == READ);
    c.en_ins       = (s == INS);
    c.we           = (s == INIT) || (s == INS);
    c.change_index = (s == NEXT);
    c.en_traceB    = (s == TRACE);
    c.busy         = !(s inside {IDLE, DONE, ERR});
    c.done         = (s == DONE);
    c.err          = (s == ERR);
    return c;
  endfunction

endpackage

// File: rtl/nw_seq_store.sv
// Two N-entry symbol register files (A rows, B cols): one shared write port,
// one asynchronous read port per sequence.
module nw_seq_store
  import nw_pkg::*;
#(
  parameter int N       = 5,
  parameter int BitAddr = $clog2(N+1)
) (
  input  logic               clk,
  input  logic               we,
  input  logic               sel,
  input  logic [BitAddr:0]   addr,
  input  logic [2:0]         sym,
  input  logic [BitAddr-1:0] ia,
  input  logic [BitAddr-1:0] ib,
  output logic [2:0]         sym_a,
  output logic [2:0]         sym_b
);

  localparam logic [BitAddr:0] LIM = (BitAddr+1)'(N);

  logic [N-1:0][2:0] mem_a, mem_b;

  // Contents survive reset so a loaded pair can be rerun after an abort.
  always_ff @(posedge clk) begin
    if (we && (addr < LIM)) begin
      if (sel) mem_b[addr[BitAddr-1:0]] <= sym;
      else     mem_a[addr[BitAddr-1:0]] <= sym;
    end
  end

  assign sym_a = mem_a[ia];
  assign sym_b = mem_b[ib];

endmodule

// File: rtl/nw_fill_sequencer.sv
// Control FSM ahead of the NW datapath: init, row-major cell fill (read/insert/next),
// traceback, with handshake timeouts and an early end_filling protocol check.
module nw_fill_sequencer
  import nw_pkg::*;
#(
  parameter int N          = 5,
  parameter int BitAddr    = $clog2(N+1),
  parameter int INS_CYCLES = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             seq_we,
  input  logic             seq_sel,
  input  logic [BitAddr:0] seq_addr,
  input  logic [2:0]       seq_sym,
  input  logic             end_init,
  input  logic             calculated,
  input  logic             end_filling,
  input  logic             end_c,
  output logic [2:0]       a,
  output logic [2:0]       b,
  output logic             en_init,
  output logic             en_read,
  output logic             en_ins,
  output logic             we,
  output logic             change_index,
  output logic             en_traceB,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int                 CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0]      TMO_LAST = CW'(TIMEOUT-1);
  localparam logic [CW-1:0]      INS_LAST = CW'(INS_CYCLES-1);
  localparam logic [BitAddr-1:0] IDX_ONE  = BitAddr'(1);
  localparam logic [BitAddr-1:0] IDX_N    = BitAddr'(N);

  state_t             state_q, state_nx;
  ctl_t               ctl_q;
  logic [CW-1:0]      cnt_q;
  logic [BitAddr-1:0] i_q, j_q;
  logic [2:0]         sym_a, sym_b;
  logic               store_we, last_cell, ins_end, timed_out;

  assign store_we  = seq_we && (state_q inside {IDLE, DONE, ERR});
  assign last_cell = (i_q == IDX_N) && (j_q == IDX_N);
  assign ins_end   = (state_q == INS) && (cnt_q == INS_LAST);
  assign timed_out = (cnt_q == TMO_LAST);

  nw_seq_store #(.N(N), .BitAddr(BitAddr)) u_store (
    .clk   (clk),
    .we    (store_we),
    .sel   (seq_sel),
    .addr  (seq_addr),
    .sym   (seq_sym),
    .ia    (i_q - IDX_ONE),
    .ib    (j_q - IDX_ONE),
    .sym_a (sym_a),
    .sym_b (sym_b)
  );

  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE:    if (start) state_nx = INIT;
      INIT:    if (end_init) state_nx = READ; else if (timed_out) state_nx = ERR;
      READ:    if (calculated) state_nx = INS; else if (timed_out) state_nx = ERR;
      INS:     if (ins_end) state_nx = last_cell ? TRACE : NEXT;
      NEXT:    state_nx = READ;
      TRACE:   if (end_c) state_nx = DONE; else if (timed_out) state_nx = ERR;
      DONE:    if (start) state_nx = INIT;
      default: state_nx = ERR;
    endcase
    // end_filling is legal only once the final insertion burst is finishing.
    if (end_filling && (state_q inside {INIT, READ, INS, NEXT}) && !(ins_end && last_cell))
      state_nx = ERR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ctl_q   <= '0;
      cnt_q   <= '0;
      i_q     <= IDX_ONE;
      j_q     <= IDX_ONE;
      a       <= '0;
      b       <= '0;
    end else begin
      state_q <= state_nx;
      ctl_q   <= ctl_of(state_nx);
      if (state_nx != state_q)                        cnt_q <= '0;
      else if (state_q inside {INIT, READ, INS, TRACE}) cnt_q <= cnt_q + 1'b1;
      // Index advances as INS closes, so the store already shows the next cell during NEXT.
      if (state_nx == INIT) begin
        i_q <= IDX_ONE;
        j_q <= IDX_ONE;
      end else if ((state_q == INS) && (state_nx == NEXT)) begin
        if (j_q == IDX_N) begin
          j_q <= IDX_ONE;
          i_q <= i_q + 1'b1;
        end else begin
          j_q <= j_q + 1'b1;
        end
      end
      if ((state_nx == READ) && (state_q != READ)) begin
        a <= sym_a;
        b <= sym_b;
      end
    end
  end

  assign en_init      = ctl_q.en_init;
  assign en_read      = ctl_q.en_read;
  assign en_ins       = ctl_q.en_ins;
  assign we           = ctl_q.we;
  assign change_index = ctl_q.change_index;
  assign en_traceB    = ctl_q.en_traceB;
  assign busy         = ctl_q.busy;
  assign done         = ctl_q.done;
  assign err          = ctl_q.err;

endmodule

// File: tb/tb_nw_fill_sequencer.sv
// Bench for nw_fill_sequencer: table of run configurations driven by a cycle-level
// datapath responder, checked against a row-major cell model of the loaded sequences.
module tb_nw_fill_sequencer;
  import nw_pkg::*;

  localparam int N          = 5;
  localparam int BA         = $clog2(N+1);
  localparam int INS_CYCLES = 4;
  localparam int TIMEOUT    = 64;
  localparam int BUDGET     = 4000;

  logic          clk = 1'b0, rst = 1'b1;
  logic          start = 1'b0, seq_we = 1'b0, seq_sel = 1'b0;
  logic [BA:0]   seq_addr = '0;
  logic [2:0]    seq_sym = '0;
  logic          end_init = 1'b0, calculated = 1'b0, end_filling = 1'b0, end_c = 1'b0;
  logic [2:0]    a, b;
  logic          en_init, en_read, en_ins, we, change_index, en_traceB, busy, done, err;

  int errors = 0, checks = 0, viol = 0;
  logic [2:0] ma [N];
  logic [2:0] mb [N];
  logic [2:0] codes [4];
  logic [2:0] fix_a [N];
  logic [2:0] fix_b [N];

  typedef struct {
    int rnd, init_d, calc_d, trace_d, stall_cell, fill_cell, rst_cell, disturb;
    int exp_err, exp_cells, exp_lat;
  } vec_t;
  vec_t tbl [16];

  always #5 clk = ~clk;

  nw_fill_sequencer #(.N(N), .BitAddr(BA), .INS_CYCLES(INS_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .seq_we(seq_we), .seq_sel(seq_sel),
    .seq_addr(seq_addr), .seq_sym(seq_sym), .end_init(end_init), .calculated(calculated),
    .end_filling(end_filling), .end_c(end_c), .a(a), .b(b), .en_init(en_init),
    .en_read(en_read), .en_ins(en_ins), .we(we), .change_index(change_index),
    .en_traceB(en_traceB), .busy(busy), .done(done), .err(err)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if ((int'(en_init) + int'(en_read) + int'(en_ins) + int'(en_traceB)) > 1 ||
          (we && !(en_init || en_ins))) begin
        viol++;
        $display("FAIL exclusivity @%0t: init=%0b read=%0b ins=%0b trace=%0b we=%0b (required one-hot, we only in init/ins)",
                 $time, en_init, en_read, en_ins, en_traceB, we);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic write_sym(input logic sel, input int addr, input logic [2:0] sym);
    @(negedge clk);
    seq_we = 1'b1; seq_sel = sel; seq_addr = addr[BA:0]; seq_sym = sym;
    @(negedge clk);
    seq_we = 1'b0;
  endtask

  task automatic run(input int t, input vec_t v);
    int ph, entry, err_cyc, cells, pulses, cdel, bad_stab, k, r, c;
    logic [4:0] vec, pvec;
    logic [2:0] ra, rb;
    bit fin, aborted, saw_trace;
    if (err) do_reset();
    for (int q = 0; q < N; q++) begin
      ma[q] = v.rnd != 0 ? codes[$urandom_range(0, 3)] : fix_a[q];
      mb[q] = v.rnd != 0 ? codes[$urandom_range(0, 3)] : fix_b[q];
    end
    for (int q = 0; q < N; q++) begin
      write_sym(1'b0, q, ma[q]);
      write_sym(1'b1, q, mb[q]);
    end
    @(negedge clk);
    start = 1'b1;
    if (v.rnd != 0) begin
      // write coincident with start must be the one the run uses
      k = $urandom_range(0, N-1);
      ma[k] = codes[$urandom_range(0, 3)];
      seq_we = 1'b1; seq_sel = 1'b0; seq_addr = k[BA:0]; seq_sym = ma[k];
    end
    @(negedge clk);
    start = 1'b0; seq_we = 1'b0;
    chk($sformatf("v%0d/done_cleared", t), done, 0);
    chk($sformatf("v%0d/init_first", t), {en_init, busy}, 2'b11);
    ph = 0; entry = 0; err_cyc = -1; cells = 0; pulses = 0; cdel = 0; bad_stab = 0;
    pvec = '0; fin = 0; aborted = 0; saw_trace = 0; ra = '0; rb = '0;
    for (int cyc = 0; cyc < BUDGET && !fin; cyc++) begin
      end_init = 1'b0; calculated = 1'b0; end_c = 1'b0; end_filling = 1'b0;
      start = 1'b0; seq_we = 1'b0;
      vec = {en_init, en_read, en_ins, en_traceB, change_index};
      if (err) begin
        err_cyc = cyc; fin = 1;
        chk($sformatf("v%0d/err_quiet", t), {vec, we}, 0);
      end else if (done) begin
        fin = 1;
      end else begin
        if (vec != pvec) begin
          if (pvec == 5'b00100) chk($sformatf("v%0d/ins_len", t), ph, INS_CYCLES);
          ph = 0; entry = cyc;
          if (en_read) begin
            cells++; ra = a; rb = b;
            cdel = (cells-1 == v.stall_cell) ? BUDGET :
                   (v.calc_d < 0 ? int'($urandom_range(0, 5)) : v.calc_d);
          end
          if (change_index) pulses++;
          if (en_traceB) saw_trace = 1;
        end
        if (en_read && (a !== ra || b !== rb)) bad_stab++;
        if (en_ins && ph == 0) begin
          k = cells - 1; r = k / N; c = k % N;
          chk($sformatf("v%0d/cell%0d", t, k), {a, b}, {ma[r], mb[c]});
        end
        if (v.rnd != 0) begin
          if (!en_init)   end_init   = 1'($urandom_range(0, 1));
          if (!en_read)   calculated = 1'($urandom_range(0, 1));
          if (!en_traceB) end_c      = 1'($urandom_range(0, 1));
        end
        if (en_init && ph == v.init_d)  end_init = 1'b1;
        if (en_read && ph == cdel)      calculated = 1'b1;
        if (en_traceB && ph == v.trace_d) end_c = 1'b1;
        if (en_read && ph == 0 && cells-1 == v.fill_cell) end_filling = 1'b1;
        if (v.disturb != 0 && en_read && ph == 0 && cells == 3) begin
          start = 1'b1; seq_we = 1'b1; seq_sel = 1'b0; seq_addr = '0; seq_sym = ~ma[0];
        end
        if (en_ins && ph == 1 && cells-1 == v.rst_cell) begin
          #2 rst = 1'b1;
          #1;
          chk($sformatf("v%0d/rst_drop", t), {en_ins, we, busy}, 0);
          chk($sformatf("v%0d/rst_ab", t), {a, b}, 0);
          @(negedge clk);
          rst = 1'b0;
          aborted = 1; fin = 1;
        end
        ph++; pvec = vec;
      end
      if (!fin) @(negedge clk);
    end
    end_init = 1'b0; calculated = 1'b0; end_c = 1'b0; end_filling = 1'b0;
    start = 1'b0; seq_we = 1'b0;
    if (!aborted) begin
      chk($sformatf("v%0d/finished", t), fin, 1);
      chk($sformatf("v%0d/err", t), err, v.exp_err);
      chk($sformatf("v%0d/done", t), done, v.exp_err == 0);
      chk($sformatf("v%0d/busy", t), busy, 0);
      chk($sformatf("v%0d/cells", t), cells, v.exp_cells);
      chk($sformatf("v%0d/pulses", t), pulses, v.exp_cells > 0 ? v.exp_cells - 1 : 0);
      chk($sformatf("v%0d/ab_stable", t), bad_stab, 0);
      chk($sformatf("v%0d/trace_seen", t), saw_trace, v.exp_cells == N*N);
      if (v.exp_err != 0) chk($sformatf("v%0d/err_latency", t), err_cyc - entry, v.exp_lat);
    end
  endtask

  initial begin
    codes = '{SYM_A, SYM_C, SYM_G, SYM_T};
    fix_a = '{SYM_C, SYM_A, SYM_C, SYM_T, SYM_G};
    fix_b = '{SYM_G, SYM_A, SYM_T, SYM_G, SYM_C};
    //         rnd init calc trace stall fill rst dist err cells lat
    tbl[0]  = '{0, 24,  2,  5, -1, -1, -1, 0, 0, 25,  0};
    tbl[1]  = '{0,  3,  1,  4,  7, -1, -1, 0, 1,  8, 64};
    tbl[2]  = '{0,  5,  2,  3, -1, 10, -1, 0, 1, 11,  1};
    tbl[3]  = '{0, 24,  2,  5, -1, -1,  3, 0, 0,  4,  0};
    tbl[4]  = '{0, 24,  2,  5, -1, -1, -1, 0, 0, 25,  0};
    tbl[5]  = '{0,  4,  1,  2, -1, -1, -1, 1, 0, 25,  0};
    tbl[6]  = '{0,  0,  0,  0, -1, -1, -1, 0, 0, 25,  0};
    tbl[7]  = '{0, 63,  1,  1, -1, -1, -1, 0, 0, 25,  0};
    tbl[8]  = '{0, 64,  1,  1, -1, -1, -1, 0, 1,  0, 64};
    tbl[9]  = '{0,  2,  1, 63, -1, -1, -1, 0, 0, 25,  0};
    tbl[10] = '{0,  2,  1, 64, -1, -1, -1, 0, 1, 25, 64};
    tbl[11] = '{0,  2, 63,  2, -1, -1, -1, 0, 0, 25,  0};
    for (int q = 12; q < 16; q++) tbl[q] = '{1, 7, -1, 3, -1, -1, -1, 0, 0, 25, 0};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {a, b, en_init, en_read, en_ins, we, change_index, en_traceB, busy, done, err}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {busy, done, err, en_init}, 0);
    for (int t = 0; t < 16; t++) run(t, tbl[t]);
    chk("exclusivity_violations", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
